// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared constants for the data-RAM arbiter and its neighbours
//               (RAM geometry, arbiter state encoding, master indices).
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    // RAM geometry shared with the RAM instance and the MEM stage
    localparam int ADDR_W_DEFAULT = 5;
    localparam int DATA_W_DEFAULT = 32;

    // Arbiter state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    // Master indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin picker. A lone requester wins;
//               on a tie the master that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Tie goes to the master other than the previous winner
    always_comb begin
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares the single-port data RAM between m0 (CPU MEM stage) and
//               m1 (DMA/debug loader). Per-access round robin, optional locked
//               bursts of up to BURST_MAX beats, registered read return.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // With BURST_MAX=1 every burst would end on its first beat, so lock is inert
    localparam logic       c_lock_en    = (BURST_MAX > 1);
    localparam logic [3:0] c_burst_last = 4'(BURST_MAX);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_owner;
    logic       w_last_owner_nxt;
    logic [3:0] r_beat_cnt;
    logic [3:0] w_beat_cnt_nxt;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;
    logic       w_own_req;
    logic       w_own_lock;

    rr_pick2 u_pick (
        .req  ({m1_req, m0_req}),
        .last (r_last_owner),
        .gnt  (w_pick)
    );

    // Request/lock of whichever master currently owns the RAM (OWN states only)
    assign w_own_req  = (r_state == OWN1) ? m1_req  : m0_req;
    assign w_own_lock = (r_state == OWN1) ? m1_lock : m0_lock;

    // State register: FSM state, round-robin history and burst beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= M1;
            r_beat_cnt   <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, track burst length while owned
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_gnt[0]) begin
                    w_last_owner_nxt = M0;
                    if (m0_lock && c_lock_en) begin
                        w_state_nxt    = OWN0;
                        w_beat_cnt_nxt = 4'd1;
                    end
                end else if (w_gnt[1]) begin
                    w_last_owner_nxt = M1;
                    if (m1_lock && c_lock_en) begin
                        w_state_nxt    = OWN1;
                        w_beat_cnt_nxt = 4'd1;
                    end
                end
            end
            OWN0, OWN1: begin
                if (w_own_req) begin
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                    if (!w_own_lock || (r_beat_cnt + 4'd1 == c_burst_last)) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    // Owner dropped its request: release after a one-cycle bubble
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs: grants (none while in reset) and RAM port driven by the winner
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            case (r_state)
                IDLE:    w_gnt = w_pick;
                OWN0:    w_gnt = {1'b0, m0_req};
                OWN1:    w_gnt = {m1_req, 1'b0};
                default: w_gnt = 2'b00;
            endcase
        end
        m0_gnt    = w_gnt[0];
        m1_gnt    = w_gnt[1];
        ram_ce    = |w_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt[0]) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (w_gnt[1]) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    // Read return: capture RAM data at the end of a granted read cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= w_gnt[0] & ~m0_we;
            m1_rvalid <= w_gnt[1] & ~m1_we;
            if (w_gnt[0] && !m0_we) begin
                m0_rdata <= ram_rdata;
            end
            if (w_gnt[1] && !m1_we) begin
                m1_rdata <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a behavioural RAM and
//               an ownership/round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int BURST_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic        lock  [2];
    logic [4:0]  addr  [2];
    logic [31:0] wdata [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] ram [32];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ref_mem [32];
    int          owner;      // -1 when nobody holds a lock
    int          beats;
    int          last;
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    int          win;        // winner of the most recent cycle, -1 if none

    ram_arbiter #(.ADDR_W(5), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_lock   (lock[0]),
        .m0_addr   (addr[0]),
        .m0_wdata  (wdata[0]),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_lock   (lock[1]),
        .m1_addr   (addr[1]),
        .m1_wdata  (wdata[1]),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 32x32 RAM: combinational read, write on rising edge
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_ce && ram_we) ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        beats  = 0;
        last   = 1;
        exp_rv = '{1'b0, 1'b0};
        exp_rd = '{32'd0, 32'd0};
    endtask

    // One clock cycle: settle inputs, check every output, advance the model
    task automatic tick();
        int w;
        #1;
        if (!rst_n) model_reset();
        w = -1;
        if (rst_n) begin
            if (owner >= 0) begin
                if (req[owner]) w = owner;
            end else if (req[0] && req[1]) begin
                w = 1 - last;
            end else if (req[0]) begin
                w = 0;
            end else if (req[1]) begin
                w = 1;
            end
        end
        chk("gnt0",   32'(m0_gnt),    32'(w == 0));
        chk("gnt1",   32'(m1_gnt),    32'(w == 1));
        chk("ce",     32'(ram_ce),    32'(w >= 0));
        chk("we",     32'(ram_we),    (w >= 0) ? 32'(we[w]) : 32'd0);
        chk("addr",   32'(ram_addr),  (w >= 0) ? 32'(addr[w]) : 32'd0);
        chk("wdata",  ram_wdata,      (w >= 0) ? wdata[w] : 32'd0);
        chk("rvalid0", 32'(m0_rvalid), 32'(exp_rv[0]));
        chk("rvalid1", 32'(m1_rvalid), 32'(exp_rv[1]));
        chk("rdata0", m0_rdata, exp_rd[0]);
        chk("rdata1", m1_rdata, exp_rd[1]);
        win = w;
        if (rst_n) begin
            exp_rv = '{1'b0, 1'b0};
            if (w >= 0) begin
                if (we[w]) begin
                    ref_mem[addr[w]] = wdata[w];
                end else begin
                    exp_rv[w] = 1'b1;
                    exp_rd[w] = ref_mem[addr[w]];
                end
            end
            if (owner >= 0) begin
                if (w < 0) begin
                    owner = -1;
                end else begin
                    beats++;
                    if (!lock[owner] || beats == BURST_MAX) owner = -1;
                end
            end else if (w >= 0) begin
                last = w;
                if (lock[w] && BURST_MAX > 1) begin
                    owner = w;
                    beats = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; lock[m] = 1'b0;
            addr[m] = 5'd0; wdata[m] = 32'd0;
        end
    endtask

    task automatic set_m(input int m, input logic r, input logic w, input logic l,
                         input logic [4:0] a, input logic [31:0] d);
        req[m] = r; we[m] = w; lock[m] = l; addr[m] = a; wdata[m] = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int done1;
        for (int i = 0; i < 32; i++) begin
            ram[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        model_reset();
        win = -1;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write then read by m0
        set_m(0, 1, 1, 0, 5'd5, 32'hDEADBEEF); tick();
        set_m(0, 1, 0, 0, 5'd5, 32'd0);        tick();
        chk("single_rd_rvalid", 32'(m0_rvalid), 32'd1);
        chk("single_rd_data",   m0_rdata, 32'hDEADBEEF);
        idle_inputs(); tick();

        // Tie round robin from reset
        do_reset();
        set_m(0, 1, 0, 0, 5'd5, 32'd0);
        set_m(1, 1, 0, 0, 5'd5, 32'd0);
        tick();
        chk("tie_first_m0", 32'(win), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        idle_inputs(); tick();

        // Locked burst by m1 with m0 waiting to write
        done1 = 0;
        set_m(0, 1, 1, 0, 5'd9, 32'hA5A5A5A5);
        for (int i = 0; i < 20 && done1 < 6; i++) begin
            set_m(1, 1, 0, 1, 5'(done1), 32'd0);
            tick();
            if (win == 1) done1++;
            if (win == 0) req[0] = 1'b0;
        end
        chk("burst_done", 32'(done1), 32'd6);
        idle_inputs(); tick();

        // Early unlock: m0 locks then drops req for a cycle
        do_reset();
        set_m(0, 1, 0, 1, 5'd1, 32'd0);
        set_m(1, 1, 0, 0, 5'd2, 32'd0);
        tick();
        req[0] = 1'b0;
        tick();
        chk("bubble_nogrant", 32'(win), 32'hFFFFFFFF);
        tick();
        chk("after_bubble_m1", 32'(win), 32'd1);
        idle_inputs(); tick();

        // Reset in the middle of an m0 burst
        set_m(0, 1, 1, 0, 5'd7, 32'd1); tick();
        idle_inputs(); tick();
        set_m(0, 1, 0, 1, 5'd7, 32'd0); tick();
        set_m(0, 1, 1, 1, 5'd7, 32'hBADBAD00);
        rst_n = 1'b0;
        tick();
        idle_inputs();
        rst_n = 1'b1;
        set_m(0, 1, 0, 0, 5'd7, 32'd0);
        set_m(1, 1, 0, 0, 5'd3, 32'd0);
        tick();
        chk("post_reset_tie_m0", 32'(win), 32'd0);
        idle_inputs(); tick();
        chk("addr7_kept", m0_rdata, 32'd1);

        // Write/read turnaround on m1
        set_m(1, 1, 1, 0, 5'd31, 32'h12345678); tick();
        set_m(1, 1, 0, 0, 5'd31, 32'd0);        tick();
        idle_inputs(); tick();
        chk("turnaround_data", m1_rdata, 32'h12345678);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                set_m(m, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                      $urandom_range(0, 1), 5'($urandom), $urandom);
            end
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
        for (int i = 0; i < 32; i++) chk("mem_final", ram[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
